// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    // Arbiter lock state: no owner, or exactly one owner holding the lock.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int UART_N_REQ_DEF        = 4;
    localparam int UART_IDLE_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side byte handshakes of the UART arbiter.
// Latency: none (wires only).
// Backpressure: valid/ready on both the requester and transmitter sides.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = uart_pkg::UART_N_REQ_DEF
);
    logic [N_REQ-1:0][7:0] i_req_data;
    logic [N_REQ-1:0]      i_req_valid;
    logic [N_REQ-1:0]      i_req_last;
    logic [N_REQ-1:0]      o_req_ready;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic [N_REQ-1:0]      o_grant;
    logic                  o_abort;

    // Arbiter side.
    modport slave (
        input  i_req_data, i_req_valid, i_req_last, i_tx_ready,
        output o_req_ready, o_tx_data, o_tx_valid, o_grant, o_abort
    );

    // Requesters plus transmitter side.
    modport master (
        output i_req_data, i_req_valid, i_req_last, i_tx_ready,
        input  o_req_ready, o_tx_data, o_tx_valid, o_grant, o_abort
    );
endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin picker: one-hot winner, searching upward from the slot after i_ptr.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is used.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_win
);

    logic [PW-1:0] w_idx;
    logic          w_found;

    // Walk ptr+1 .. ptr+N_REQ (wrapping) and take the first active request.
    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter feeding one UART transmitter through a 1-byte buffer.
// Latency: grant one cycle after request; an accepted byte appears on o_tx_data next cycle.
// Backpressure: owner ready only while the buffer is empty; the buffer holds until i_tx_ready.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = UART_N_REQ_DEF,
    parameter int IDLE_TIMEOUT = UART_IDLE_TIMEOUT_DEF
) (
    input logic                i_clk,
    input logic                i_rst_n,
    uart_tx_arbiter_if.slave   bus
);

    localparam int PW = $clog2(N_REQ);
    localparam int SW = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_owner;
    logic [N_REQ-1:0] r_grant;
    logic [SW-1:0]    r_stall;
    logic             r_abort;
    logic             r_buf_full;
    logic [7:0]       r_buf_data;

    logic [N_REQ-1:0] w_win;
    logic [PW-1:0]    w_win_idx;
    logic [N_REQ-1:0] w_ready;
    logic             w_owner_vld;
    logic             w_owner_last;
    logic [7:0]       w_owner_dat;
    logic             w_up;
    logic             w_dn;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .i_req (bus.i_req_valid),
        .i_ptr (r_ptr),
        .o_win (w_win)
    );

    // Index of the one-hot winner, stored so the owner's lanes can be muxed directly.
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx = PW'(i);
            end
        end
    end

    assign w_owner_vld  = bus.i_req_valid[r_owner];
    assign w_owner_last = bus.i_req_last[r_owner];
    assign w_owner_dat  = bus.i_req_data[r_owner];

    // Ready depends on the buffer being empty, so fill and drain never share a cycle.
    assign w_ready = (r_state == ST_LOCKED && !r_buf_full) ? r_grant : '0;
    assign w_up    = (r_state == ST_LOCKED) && !r_buf_full && w_owner_vld;
    assign w_dn    = r_buf_full && bus.i_tx_ready;

    // Lock FSM: arbitrate in IDLE, release on last byte or on stall timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= PW'(N_REQ - 1);
            r_owner <= '0;
            r_grant <= '0;
            r_stall <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|bus.i_req_valid) begin
                        r_state <= ST_LOCKED;
                        r_grant <= w_win;
                        r_owner <= w_win_idx;
                        r_stall <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_up && w_owner_last) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_owner;
                        r_grant <= '0;
                        r_stall <= '0;
                    end else if (w_owner_vld) begin
                        r_stall <= '0;
                    end else if (r_stall == SW'(IDLE_TIMEOUT - 1)) begin
                        // This idle cycle is number IDLE_TIMEOUT: revoke the lock.
                        r_state <= ST_IDLE;
                        r_ptr   <= r_owner;
                        r_grant <= '0;
                        r_stall <= '0;
                        r_abort <= 1'b1;
                    end else begin
                        r_stall <= r_stall + SW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Single output byte buffer: filled by the owner, drained by the transmitter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
        end else if (w_up) begin
            r_buf_full <= 1'b1;
            r_buf_data <= w_owner_dat;
        end else if (w_dn) begin
            r_buf_full <= 1'b0;
        end
    end

    assign bus.o_req_ready = w_ready;
    assign bus.o_tx_valid  = r_buf_full;
    assign bus.o_tx_data   = r_buf_data;
    assign bus.o_grant     = r_grant;
    assign bus.o_abort     = r_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic.
// Latency: n/a.
// Backpressure: transmitter ready is driven directly or randomly.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ        (N),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Per-requester pending bytes, {last, data}.
    logic [8:0] src_q[N][$];
    bit         hold[N];
    int         sleep_c[N];

    // Reference model: current owner (-1 = none), last winner, idle count, buffer.
    int         m_owner;
    int         m_last;
    int         m_stall;
    bit         m_full;
    bit         m_abort;
    logic [7:0] m_data;

    logic [7:0] tx_log[$];
    int         own_log[$];
    int         acc_cyc[N];
    int         abort_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_stall = 0;
        m_full  = 1'b0;
        m_abort = 1'b0;
        m_data  = 8'h00;
    endfunction

    function automatic bit all_idle();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e && !m_full && (m_owner < 0);
    endfunction

    // One clock: drive from queues, compare outputs to the model, advance the model.
    task automatic cycle();
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic [7:0]   d[N];
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        int           up_i;
        bit           dn;
        for (int i = 0; i < N; i++) begin
            if (rst_n && src_q[i].size() > 0 && !hold[i]) begin
                v[i] = 1'b1;
                d[i] = src_q[i][0][7:0];
                l[i] = src_q[i][0][8];
            end else begin
                v[i] = 1'b0;
                d[i] = 8'($urandom);
                l[i] = 1'($urandom);
            end
            bus.i_req_data[i] = d[i];
        end
        bus.i_req_valid = v;
        bus.i_req_last  = l;
        #1;
        if (!rst_n) model_reset();
        e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_ready = (m_owner >= 0 && !m_full) ? e_grant : '0;
        chk("grant",    32'(bus.o_grant),     32'(e_grant));
        chk("ready",    32'(bus.o_req_ready), 32'(e_ready));
        chk("tx_valid", 32'(bus.o_tx_valid),  32'(m_full));
        chk("tx_data",  32'(bus.o_tx_data),   32'(m_data));
        chk("abort",    32'(bus.o_abort),     32'(m_abort));
        if (bus.o_abort === 1'b1) abort_cyc = cyc;
        if (rst_n) begin
            dn   = m_full && bus.i_tx_ready;
            up_i = -1;
            if (m_owner >= 0 && !m_full && v[m_owner]) up_i = m_owner;
            m_abort = 1'b0;
            if (dn) begin
                tx_log.push_back(m_data);
                m_full = 1'b0;
            end
            if (up_i >= 0) begin
                m_full = 1'b1;
                m_data = d[up_i];
                void'(src_q[up_i].pop_front());
                acc_cyc[up_i] = cyc;
            end
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (m_owner < 0 && v[j]) m_owner = j;
                end
                if (m_owner >= 0) begin
                    m_stall = 0;
                    own_log.push_back(m_owner);
                end
            end else if (up_i >= 0 && l[up_i]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_stall = 0;
            end else if (v[m_owner]) begin
                m_stall = 0;
            end else begin
                m_stall++;
                if (m_stall == TO) begin
                    m_abort = 1'b1;
                    m_last  = m_owner;
                    m_owner = -1;
                    m_stall = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_drain(input int max);
        int k = 0;
        while (!all_idle() && k < max) begin
            cycle();
            k++;
        end
        chk("drain_bound", 32'(k < max), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        bus.i_req_data  = '0;
        bus.i_req_valid = '0;
        bus.i_req_last  = '0;
        bus.i_tx_ready  = 1'b1;
        for (int i = 0; i < N; i++) begin
            hold[i]    = 1'b0;
            sleep_c[i] = 0;
            acc_cyc[i] = -1;
        end
        abort_cyc = -1;
        model_reset();
        @(negedge clk);

        // Reset state: all outputs low while held in reset.
        repeat (3) cycle();
        rst_n = 1'b1;

        // Two single-byte messages, requesters 0 and 2; requester 0 goes first.
        tx_log.delete();
        own_log.delete();
        src_q[0].push_back({1'b1, 8'h41});
        src_q[2].push_back({1'b1, 8'h42});
        run_drain(40);
        chk("t1_byte0",  32'(tx_log[0]), 32'h41);
        chk("t1_byte1",  32'(tx_log[1]), 32'h42);
        chk("t1_owner0", 32'(own_log[0]), 32'd0);
        chk("t1_owner1", 32'(own_log[1]), 32'd2);

        // Pointer to 0, then requester 1 message against a continuously valid requester 3.
        src_q[0].push_back({1'b1, 8'h10});
        run_drain(40);
        tx_log.delete();
        src_q[1].push_back({1'b0, 8'h75});
        src_q[1].push_back({1'b0, 8'h77});
        src_q[1].push_back({1'b1, 8'h75});
        src_q[3].push_back({1'b0, 8'hC0});
        src_q[3].push_back({1'b0, 8'hC1});
        src_q[3].push_back({1'b1, 8'hC2});
        run_drain(80);
        chk("t2_b0", 32'(tx_log[0]), 32'h75);
        chk("t2_b1", 32'(tx_log[1]), 32'h77);
        chk("t2_b2", 32'(tx_log[2]), 32'h75);
        chk("t2_b3", 32'(tx_log[3]), 32'hC0);

        // Transmitter stalled 20 cycles with the buffer full.
        tx_log.delete();
        bus.i_tx_ready = 1'b0;
        src_q[2].push_back({1'b0, 8'h5A});
        src_q[2].push_back({1'b1, 8'h5B});
        k = 0;
        while (!m_full && k < 20) begin
            cycle();
            k++;
        end
        chk("t3_fill_bound", 32'(k < 20), 32'd1);
        repeat (20) cycle();
        chk("t3_valid", 32'(bus.o_tx_valid),  32'd1);
        chk("t3_data",  32'(bus.o_tx_data),   32'h5A);
        chk("t3_ready", 32'(bus.o_req_ready), 32'd0);
        bus.i_tx_ready = 1'b1;
        run_drain(40);
        chk("t3_out0", 32'(tx_log[0]), 32'h5A);
        chk("t3_out1", 32'(tx_log[1]), 32'h5B);

        // Owner 3 sends one byte then goes silent; requester 0 waits behind the lock.
        own_log.delete();
        abort_cyc = -1;
        src_q[3].push_back({1'b0, 8'h33});
        cycle();
        src_q[0].push_back({1'b1, 8'h44});
        run_drain(80);
        // Eight idle cycles follow the accepted byte; the pulse is seen on the next one.
        chk("t4_abort_delay", 32'(abort_cyc - acc_cyc[3]), 32'(TO + 1));
        chk("t4_owner0", 32'(own_log[0]), 32'd3);
        chk("t4_owner1", 32'(own_log[1]), 32'd0);

        // Asynchronous reset in the middle of a message with the buffer full.
        bus.i_tx_ready = 1'b0;
        src_q[1].push_back({1'b0, 8'hA1});
        src_q[1].push_back({1'b0, 8'hA2});
        src_q[1].push_back({1'b1, 8'hA3});
        k = 0;
        while (!m_full && k < 20) begin
            cycle();
            k++;
        end
        chk("t5_fill_bound", 32'(k < 20), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(bus.o_tx_valid),  32'd0);
        chk("t5_rst_grant", 32'(bus.o_grant),     32'd0);
        chk("t5_rst_ready", 32'(bus.o_req_ready), 32'd0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        model_reset();
        @(negedge clk);
        repeat (2) cycle();
        rst_n = 1'b1;
        bus.i_tx_ready = 1'b1;
        own_log.delete();
        src_q[0].push_back({1'b1, 8'h01});
        src_q[1].push_back({1'b1, 8'h02});
        src_q[2].push_back({1'b1, 8'h03});
        run_drain(60);
        chk("t5_first_owner", 32'(own_log[0]), 32'd0);

        // Random traffic: random message lengths, valid drops, long silences, tx stalls.
        for (int c = 0; c < 1500; c++) begin
            bus.i_tx_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 7) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        src_q[i].push_back({1'(b == len - 1), 8'($urandom)});
                end
                if (sleep_c[i] > 0) sleep_c[i]--;
                else if ($urandom_range(0, 39) == 0) sleep_c[i] = $urandom_range(4, 14);
                hold[i] = (sleep_c[i] > 0) || ($urandom_range(0, 4) == 0);
            end
            cycle();
        end
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        bus.i_tx_ready = 1'b1;
        run_drain(500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of byte-stream requesters (2..8).
REQ-002 Parameter IDLE_TIMEOUT, default 1024: cycles a locked requester may stall before its grant is revoked (>=2).
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_req_data  in  N_REQ x 8  byte offered by each requester.
REQ-006 i_req_valid  in  N_REQ  per-requester byte-valid.
REQ-007 i_req_last  in  N_REQ  marks the final byte of a message; qualified by i_req_valid.
REQ-008 o_req_ready  out  N_REQ  per-requester accept; a byte transfers when valid and ready are both high.
REQ-009 o_tx_data  out  8  byte to the UART transmitter.
REQ-010 o_tx_valid  out  1  byte pending for the transmitter.
REQ-011 i_tx_ready  in  1  transmitter idle; a byte transfers when o_tx_valid and i_tx_ready are both high.
REQ-012 o_grant  out  N_REQ  one-hot owner of the message lock; all-zero when unlocked.
REQ-013 o_abort  out  1  one-cycle pulse when a lock is revoked by timeout.

Function
REQ-014 The FSM SHALL have two states: IDLE (no owner) and LOCKED (one owner).
REQ-015 In IDLE with any i_req_valid high, the FSM SHALL select a winner round-robin, starting from the requester after the last winner, and enter LOCKED next cycle with o_grant set to the winner.
REQ-016 After reset the last-winner pointer SHALL be N_REQ-1, so requester 0 has highest priority.
REQ-017 The arbiter SHALL hold one output byte buffer; o_tx_valid SHALL equal buffer-full.
REQ-018 o_req_ready[g] SHALL be high only in LOCKED, for g the owner, with the buffer empty; all other bits low.
REQ-019 An upstream transfer in cycle T SHALL fill the buffer so that o_tx_valid=1 and o_tx_data equal the byte from cycle T+1.
REQ-020 A downstream transfer SHALL empty the buffer in the following cycle; the buffer SHALL never be filled and emptied in the same cycle.
REQ-021 An upstream transfer with i_req_last=1 SHALL return the FSM to IDLE next cycle, update the last-winner pointer to the owner, and clear o_grant; the buffered byte SHALL still be delivered.
REQ-022 In IDLE, a new arbitration SHALL proceed while the buffer is still full; the new owner's ready waits for the buffer to empty.
REQ-023 Bytes of one message SHALL reach o_tx_data contiguously, in order, with no byte from another requester interleaved.
REQ-024 In LOCKED, a stall counter SHALL count cycles in which the owner's i_req_valid is low and reset to 0 on any owner-valid cycle.
REQ-025 When the stall counter reaches IDLE_TIMEOUT, the FSM SHALL go to IDLE, update the pointer, clear o_grant, and pulse o_abort for one cycle; the buffer content SHALL be kept.
REQ-026 Valid from non-owners SHALL be ignored in LOCKED; requesters may drop valid at any time without protocol error.
REQ-027 A single-byte message (valid and last in the first granted transfer) SHALL be legal.

Reset
REQ-028 During reset: FSM=IDLE, pointer=N_REQ-1, buffer empty, stall counter=0, o_tx_valid=0, o_tx_data=0, o_grant=0, o_req_ready=0, o_abort=0.
REQ-029 Reset asserted mid-message SHALL discard the buffered byte and the lock immediately.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state enum and the default N_REQ and IDLE_TIMEOUT constants.
REQ-031 The round-robin selection SHALL be a combinational sub-module uart_rr_pick taking a request vector and pointer, returning a one-hot winner.
REQ-032 The stall counter width SHALL be $clog2(IDLE_TIMEOUT+1) bits.

Verification
REQ-033 Reset, then requesters 0 and 2 both valid with bytes 0x41, 0x42 (last=1 each); i_tx_ready held high -> o_tx_data 0x41 then 0x42; o_grant 0001 then 0100.
REQ-034 Requester 1 sends 3-byte message 0x75,0x77,0x75 while requester 3 is valid throughout -> three bytes contiguous on o_tx_data before any byte from requester 3.
REQ-035 Hold i_tx_ready low 20 cycles with buffer full -> o_tx_valid stays 1, o_tx_data stable, o_req_ready all 0.
REQ-036 IDLE_TIMEOUT=8; owner sends one byte (last=0) then drops valid -> o_abort pulses exactly 8 stall cycles later; o_grant goes to 0; next requester is granted.
REQ-037 Assert i_rst_n low mid-message with buffer full -> o_tx_valid, o_grant and o_req_ready go 0 without a clock edge; after release requester 0 wins first.
